// File: rtl/flit_serializer.sv
// Parallel-to-serial packet transmitter: latches one head/body/tail packet and
// streams it as 16-bit flits under downstream valid/ready backpressure.
module flit_serializer #(
   parameter int NUM_FLITS   = 6,
   parameter int FLIT_WIDTH  = 16,
   parameter int COUNT_WIDTH = $clog2(NUM_FLITS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [FLIT_WIDTH-1:0] i_head_flit,
   input  logic [FLIT_WIDTH-1:0] i_body_flit_1,
   input  logic [FLIT_WIDTH-1:0] i_body_flit_2,
   input  logic [FLIT_WIDTH-1:0] i_body_flit_3,
   input  logic [FLIT_WIDTH-1:0] i_body_flit_4,
   input  logic [FLIT_WIDTH-1:0] i_tail_flit,
   output logic [FLIT_WIDTH-1:0] o_flit,
   output logic                  o_flit_valid,
   output logic [1:0]            o_flit_type,
   input  logic                  i_flit_ready,
   output logic                  o_done
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] FIRST_INDEX = '0;
   localparam logic [COUNT_WIDTH-1:0] LAST_INDEX  = COUNT_WIDTH'(NUM_FLITS - 1);
   localparam logic [COUNT_WIDTH-1:0] INDEX_STEP  = COUNT_WIDTH'(1);

   localparam logic [1:0] TYPE_IDLE = 2'b00;
   localparam logic [1:0] TYPE_HEAD = 2'b01;
   localparam logic [1:0] TYPE_BODY = 2'b10;
   localparam logic [1:0] TYPE_TAIL = 2'b11;

   state_t                  state_reg;
   state_t                  state_next;
   logic [COUNT_WIDTH-1:0]  index_reg;
   logic [COUNT_WIDTH-1:0]  index_next;
   logic                    done_reg;
   logic                    done_next;
   logic                    load;
   logic                    transfer;
   logic                    last_flit;

   logic [FLIT_WIDTH-1:0]   in_flits   [NUM_FLITS];
   logic [FLIT_WIDTH-1:0]   buffer_reg [NUM_FLITS];

   // Wire ordering fixes the transmit order: head, body 1..4, tail.
   assign in_flits[0] = i_head_flit;
   assign in_flits[1] = i_body_flit_1;
   assign in_flits[2] = i_body_flit_2;
   assign in_flits[3] = i_body_flit_3;
   assign in_flits[4] = i_body_flit_4;
   assign in_flits[5] = i_tail_flit;

   assign load      = (state_reg == IDLE) && i_valid;
   assign transfer  = (state_reg == SEND) && i_flit_ready;
   assign last_flit = (index_reg == LAST_INDEX);

   // Inputs are only sampled on acceptance, so changes while busy never leak in.
   generate
      for (genvar gi = 0; gi < NUM_FLITS; gi++) begin : g_buffer
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               buffer_reg[gi] <= '0;
            end else if (load) begin
               buffer_reg[gi] <= in_flits[gi];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         index_reg <= FIRST_INDEX;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         index_reg <= index_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      index_next = index_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (load) begin
               state_next = SEND;
               index_next = FIRST_INDEX;
            end
         end
         SEND: begin
            if (transfer) begin
               if (last_flit) begin
                  state_next = IDLE;
                  index_next = FIRST_INDEX;
                  done_next  = 1'b1;
               end else begin
                  index_next = index_reg + INDEX_STEP;
               end
            end
         end
         default: begin
            state_next = IDLE;
            index_next = FIRST_INDEX;
         end
      endcase
   end

   // Outputs depend only on registered state, never on i_flit_ready.
   always_comb begin
      o_ready      = 1'b0;
      o_flit_valid = 1'b0;
      o_flit       = '0;
      o_flit_type  = TYPE_IDLE;
      case (state_reg)
         IDLE: begin
            o_ready = 1'b1;
         end
         SEND: begin
            o_flit_valid = 1'b1;
            o_flit       = buffer_reg[index_reg];
            if (index_reg == FIRST_INDEX) begin
               o_flit_type = TYPE_HEAD;
            end else if (last_flit) begin
               o_flit_type = TYPE_TAIL;
            end else begin
               o_flit_type = TYPE_BODY;
            end
         end
         default: begin
            o_ready = 1'b0;
         end
      endcase
   end

   assign o_done = done_reg;

endmodule

// File: tb/tb_flit_serializer.sv
// Bench for flit_serializer: directed packets with literal expectations plus a
// randomized run checked every cycle against a queue-based packet model.
module tb_flit_serializer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [15:0] i_head_flit = '0;
   logic [15:0] i_body_flit_1 = '0;
   logic [15:0] i_body_flit_2 = '0;
   logic [15:0] i_body_flit_3 = '0;
   logic [15:0] i_body_flit_4 = '0;
   logic [15:0] i_tail_flit = '0;
   logic [15:0] o_flit;
   logic        o_flit_valid;
   logic [1:0]  o_flit_type;
   logic        i_flit_ready = 1'b1;
   logic        o_done;

   flit_serializer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_head_flit  (i_head_flit),
      .i_body_flit_1(i_body_flit_1),
      .i_body_flit_2(i_body_flit_2),
      .i_body_flit_3(i_body_flit_3),
      .i_body_flit_4(i_body_flit_4),
      .i_tail_flit  (i_tail_flit),
      .o_flit       (o_flit),
      .o_flit_valid (o_flit_valid),
      .o_flit_type  (o_flit_type),
      .i_flit_ready (i_flit_ready),
      .o_done       (o_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Model: a packet is just a queue of flits still owed downstream.
   logic [15:0] mq[$];
   bit          m_done = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (mq.size() == 0) begin
            if (i_valid) begin
               mq.push_back(i_head_flit);
               mq.push_back(i_body_flit_1);
               mq.push_back(i_body_flit_2);
               mq.push_back(i_body_flit_3);
               mq.push_back(i_body_flit_4);
               mq.push_back(i_tail_flit);
            end
         end else if (i_flit_ready) begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_done = 1'b1;
         end
      end
   end

   logic [15:0] xfer_log[$];
   logic [1:0]  type_log[$];
   int          pkt_count = 0;

   always @(negedge clk) begin
      int          sz;
      logic [15:0] e_flit;
      logic [1:0]  e_type;
      if (rst_n) begin
         sz     = mq.size();
         e_flit = (sz != 0) ? mq[0] : 16'h0000;
         e_type = (sz == 0) ? 2'b00 : (sz == 6) ? 2'b01 : (sz == 1) ? 2'b11 : 2'b10;
         check("cmp_ready", {31'b0, o_ready}, {31'b0, sz == 0});
         check("cmp_flit_valid", {31'b0, o_flit_valid}, {31'b0, sz != 0});
         check("cmp_flit", {16'b0, o_flit}, {16'b0, e_flit});
         check("cmp_flit_type", {30'b0, o_flit_type}, {30'b0, e_type});
         check("cmp_done", {31'b0, o_done}, {31'b0, m_done});
         if (o_flit_valid && i_flit_ready) begin
            xfer_log.push_back(o_flit);
            type_log.push_back(o_flit_type);
         end
         if (o_done) begin
            pkt_count++;
            $display("[%0t] packet %0d done", $time, pkt_count);
         end
      end
   end

   task automatic set_pkt(input logic [15:0] h, b1, b2, b3, b4, t);
      i_head_flit   = h;
      i_body_flit_1 = b1;
      i_body_flit_2 = b2;
      i_body_flit_3 = b3;
      i_body_flit_4 = b4;
      i_tail_flit   = t;
   endtask

   // Sends the current packet; cycle c is the c-th cycle after acceptance.
   task automatic run_pkt(input int stall_at, input int stall_len, input bit poke,
                          output int done_cyc, output int rdy_low, output int vld_cyc);
      done_cyc = -1;
      rdy_low  = 0;
      vld_cyc  = 0;
      @(posedge clk); #2;
      i_valid      = 1'b1;
      i_flit_ready = 1'b1;
      @(posedge clk); #2;
      i_valid = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         i_flit_ready = !(c >= stall_at && c < stall_at + stall_len);
         if (poke && c >= 2 && c <= 4) begin
            i_valid     = 1'b1;
            i_head_flit = 16'hDEAD;
         end else begin
            i_valid = 1'b0;
         end
         @(negedge clk);
         if (!o_ready) rdy_low++;
         if (o_flit_valid) vld_cyc++;
         if (o_done) begin
            done_cyc = c;
            break;
         end
         @(posedge clk); #2;
      end
      i_valid      = 1'b0;
      i_flit_ready = 1'b1;
   endtask

   task automatic check_std_log(input string name);
      logic [15:0] ef[6];
      logic [1:0]  et[6];
      ef = '{16'hA000, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hC0FF};
      et = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
      check({name, "_count"}, xfer_log.size(), 6);
      for (int k = 0; k < 6 && k < xfer_log.size(); k++) begin
         check({name, "_flit"}, {16'b0, xfer_log[k]}, {16'b0, ef[k]});
         check({name, "_type"}, {30'b0, type_log[k]}, {30'b0, et[k]});
      end
   endtask

   initial begin
      int dc, rl, vc, found, bad;
      logic [15:0] e12[12];

      // Reset
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("reset_ready", {31'b0, o_ready}, 1);
      check("reset_flit_valid", {31'b0, o_flit_valid}, 0);
      check("reset_flit", {16'b0, o_flit}, 0);
      check("reset_flit_type", {30'b0, o_flit_type}, 0);
      check("reset_done", {31'b0, o_done}, 0);

      // Single packet, no stall
      xfer_log.delete(); type_log.delete();
      set_pkt(16'hA000, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hC0FF);
      run_pkt(0, 0, 1'b0, dc, rl, vc);
      check("nostall_done_cycle", dc, 7);
      check("nostall_ready_low", rl, 6);
      check("nostall_valid_cycles", vc, 6);
      check_std_log("nostall");

      // Backpressure while B002 is presented
      xfer_log.delete(); type_log.delete();
      run_pkt(3, 3, 1'b0, dc, rl, vc);
      check("stall_done_cycle", dc, 10);
      check("stall_ready_low", rl, 9);
      check("stall_valid_cycles", vc, 9);
      check_std_log("stall");

      // i_valid while busy is ignored
      xfer_log.delete(); type_log.delete();
      set_pkt(16'hA000, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hC0FF);
      run_pkt(0, 0, 1'b1, dc, rl, vc);
      check("busy_done_cycle", dc, 7);
      check_std_log("busy");
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (o_flit_valid || o_done) bad++;
      end
      check("busy_no_second_pkt", bad, 0);

      // Back-to-back with i_valid held high
      xfer_log.delete(); type_log.delete();
      set_pkt(16'hA000, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hC0FF);
      @(posedge clk); #2 i_valid = 1'b1;
      @(posedge clk); #2;
      set_pkt(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666);
      found = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (o_done) begin
            found = c;
            break;
         end
      end
      check("b2b_first_done_cycle", found, 7);
      check("b2b_ready_in_done", {31'b0, o_ready}, 1);
      @(posedge clk); #2 i_valid = 1'b0;
      @(negedge clk);
      check("b2b_head_flit", {16'b0, o_flit}, 32'h1111);
      check("b2b_head_type", {30'b0, o_flit_type}, 1);
      found = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (o_done) begin
            found = 1;
            break;
         end
      end
      check("b2b_second_done", found, 1);
      e12 = '{16'hA000, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hC0FF,
              16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
      check("b2b_count", xfer_log.size(), 12);
      for (int k = 0; k < 12 && k < xfer_log.size(); k++)
         check("b2b_flit", {16'b0, xfer_log[k]}, {16'b0, e12[k]});

      // Mid-packet reset while B003 is presented
      set_pkt(16'hA000, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hC0FF);
      @(posedge clk); #2 i_valid = 1'b1;
      @(posedge clk); #2 i_valid = 1'b0;
      found = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (o_flit_valid && o_flit == 16'hB003) begin
            found = 1;
            break;
         end
      end
      check("midrst_reached_b003", found, 1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_flit_valid", {31'b0, o_flit_valid}, 0);
      check("midrst_flit", {16'b0, o_flit}, 0);
      check("midrst_done", {31'b0, o_done}, 0);
      check("midrst_ready", {31'b0, o_ready}, 1);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (o_flit_valid || o_done || !o_ready) bad++;
      end
      check("midrst_quiet_after", bad, 0);

      // Randomized traffic, checked every cycle against the model
      pkt_count = 0;
      for (int c = 0; c < 800; c++) begin
         @(posedge clk); #2;
         i_valid      = ($urandom_range(0, 2) == 0);
         i_flit_ready = ($urandom_range(0, 3) != 0);
         set_pkt(16'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom), 16'($urandom));
         if (c == 400) rst_n = 1'b0;
         if (c == 402) rst_n = 1'b1;
      end
      @(posedge clk); #2;
      i_valid      = 1'b0;
      i_flit_ready = 1'b1;
      repeat (12) @(posedge clk);
      check("rand_pkts_seen", {31'b0, pkt_count > 20}, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule

// File: doc/flit_serializer.md
Name: flit_serializer

Overview:
- Transmit-side counterpart of the flit extraction path. Accepts one complete packet in parallel: one head flit, four body flits and one tail flit.
- Emits the packet as a serial stream of 16-bit flits, one per accepted cycle, with downstream backpressure.
- Sits between the packet builder and the link/router input port that feeds the extraction logic.

Parameters:
- NUM_FLITS, 6, total flits per packet (head + body + tail).
- FLIT_WIDTH, 16, width of each flit in bits.
- COUNT_WIDTH, $clog2(NUM_FLITS), width of the flit index counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  packet on i_*_flit inputs is valid.
- o_ready  output  1  block can accept a packet.
- i_head_flit  input  FLIT_WIDTH  head flit.
- i_body_flit_1..i_body_flit_4  input  FLIT_WIDTH each  body flits 1-4, sent in that order.
- i_tail_flit  input  FLIT_WIDTH  tail flit.
- o_flit  output  FLIT_WIDTH  current serial flit.
- o_flit_valid  output  1  o_flit is valid.
- o_flit_type  output  2  00 idle, 01 head, 10 body, 11 tail.
- i_flit_ready  input  1  downstream accepts o_flit this cycle.
- o_done  output  1  one-cycle pulse after the tail flit is accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, index counter = 0, packet buffer = 0.
  - o_done = 0, o_flit_valid = 0, o_flit = 0, o_flit_type = 00, o_ready = 1.
- FSM states are IDLE and SEND.
  - o_ready = (state == IDLE).
  - o_flit_valid = (state == SEND).
- IDLE:
  - On i_valid && o_ready, latch all six flits into buffer[0..5] in the order head, body1-4, tail.
  - Set index = 0 and go to SEND.
  - If i_valid is low, stay in IDLE.
- SEND:
  - o_flit = buffer[index].
  - o_flit_type = 01 when index == 0, 11 when index == NUM_FLITS-1, otherwise 10.
  - A transfer occurs when o_flit_valid && i_flit_ready.
  - On a transfer with index < NUM_FLITS-1: index increments by 1.
  - On a transfer with index == NUM_FLITS-1:
    - index resets to 0 and state goes to IDLE;
    - o_done is registered high for exactly the next cycle.
  - i_flit_ready low holds index, o_flit and o_flit_type stable. No flit is skipped or repeated.
- Outputs are driven only from registered state and buffer; there is no combinational path from i_flit_ready to o_flit.
- When o_flit_valid is low, o_flit = 0 and o_flit_type = 00.
- Latency:
  - Packet accepted at edge T → head valid in cycle T+1.
  - With i_flit_ready held high, tail is presented in cycle T+6 and o_done is high in cycle T+7, in which o_ready is also high.
  - Minimum packet-to-packet spacing is 7 cycles; one idle cycle is mandatory.
- Boundary conditions:
  - i_valid while busy (SEND) is ignored; inputs are not sampled and the buffer is unchanged.
  - i_valid asserted in the same cycle o_done is high is accepted, since state is IDLE.
  - The index never exceeds NUM_FLITS-1; the wrap is explicit, not overflow.
  - rst_n asserted mid-packet aborts immediately: no o_done, remaining flits are discarded, and the block returns to IDLE.
  - An i_flit_ready toggle on every cycle still yields exactly six transfers per packet.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release → o_ready=1, o_flit_valid=0, o_flit=0x0000, o_flit_type=00, o_done=0.
- Single packet, no stall:
  - Stimulus: head=0xA000, body=0xB001..0xB004, tail=0xC0FF, i_valid for 1 cycle, i_flit_ready=1.
  - Required: o_flit = A000(01), B001, B002, B003, B004 (10), C0FF(11) on consecutive cycles; o_done pulses 1 cycle after C0FF; o_ready low for exactly 6 cycles.
- Backpressure:
  - Stimulus: same packet with i_flit_ready=0 for 3 cycles while B002 is presented.
  - Required: B002 is held for 4 cycles, no duplicate or missing flit, o_done delayed by 3 cycles.
- Busy input ignored:
  - Stimulus: drive i_valid=1 with head=0xDEAD during SEND.
  - Required: the stream is unchanged and no second packet is emitted.
- Back-to-back:
  - Stimulus: second packet (head=0x1111..tail=0x6666) with i_valid held high continuously.
  - Required: accepted in the o_done cycle; head 0x1111 appears one cycle later.
- Mid-packet reset:
  - Stimulus: pull rst_n low while B003 is presented.
  - Required: o_flit_valid=0 immediately, no o_done, o_ready=1 after release.
